// File: rtl/ex_mem_reg.sv
// EX->MEM pipeline register: valid/ready handshake, synchronous flush, bubbles masked to MEMOP_NONE.
// Define EXMEM_SKID_EN for the two-entry skid buffer; otherwise a single entry with a combinational ready.
`ifndef XLEN
`define XLEN 64
`endif
`ifndef REG_ADDRWIDTH
`define REG_ADDRWIDTH 5
`endif
`ifndef IMM_LEN
`define IMM_LEN 64
`endif
`ifndef MEMOP_LEN
`define MEMOP_LEN 4
`endif
`ifndef MEMOP_NONE
`define MEMOP_NONE 4'hF
`endif

module ex_mem_reg (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [`XLEN-1:0]          i_pc,
    input  logic [`XLEN-1:0]          i_inst_data,
    input  logic [`REG_ADDRWIDTH-1:0] i_rd_idx,
    input  logic [`XLEN-1:0]          i_rs1_data,
    input  logic [`XLEN-1:0]          i_rs2_data,
    input  logic [`IMM_LEN-1:0]       i_imm_data,
    input  logic [`MEMOP_LEN-1:0]     i_mem_op,
    input  logic [`XLEN-1:0]          i_exc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [`XLEN-1:0]          o_pc,
    output logic [`XLEN-1:0]          o_inst_data,
    output logic [`REG_ADDRWIDTH-1:0] o_rd_idx,
    output logic [`XLEN-1:0]          o_rs1_data,
    output logic [`XLEN-1:0]          o_rs2_data,
    output logic [`IMM_LEN-1:0]       o_imm_data,
    output logic [`MEMOP_LEN-1:0]     o_mem_op,
    output logic [`XLEN-1:0]          o_exc
);

    typedef struct packed {
        logic [`XLEN-1:0]          pc;
        logic [`XLEN-1:0]          inst_data;
        logic [`REG_ADDRWIDTH-1:0] rd_idx;
        logic [`XLEN-1:0]          rs1_data;
        logic [`XLEN-1:0]          rs2_data;
        logic [`IMM_LEN-1:0]       imm_data;
        logic [`MEMOP_LEN-1:0]     mem_op;
        logic [`XLEN-1:0]          exc;
    } beat_t;

    typedef enum logic [1:0] {
        S_EMPTY,
        S_ONE,
        S_FULL
    } state_e;

    state_e state_q, state_d;
    beat_t  main_q, main_d;
    beat_t  in_beat;
    logic   accept;
    logic   pop;
`ifdef EXMEM_SKID_EN
    beat_t  skid_q, skid_d;
`endif

    always_comb begin
        in_beat.pc        = i_pc;
        in_beat.inst_data = i_inst_data;
        in_beat.rd_idx    = i_rd_idx;
        in_beat.rs1_data  = i_rs1_data;
        in_beat.rs2_data  = i_rs2_data;
        in_beat.imm_data  = i_imm_data;
        in_beat.mem_op    = i_mem_op;
        in_beat.exc       = i_exc;
    end

    assign out_valid = (state_q != S_EMPTY);
`ifdef EXMEM_SKID_EN
    assign in_ready  = ~rst & (state_q != S_FULL);
`else
    assign in_ready  = ~rst & ((state_q == S_EMPTY) | out_ready);
`endif
    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
`ifdef EXMEM_SKID_EN
        skid_d  = skid_q;
`endif
        unique case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    state_d = S_ONE;
                    main_d  = in_beat;
                end
            end
            S_ONE: begin
`ifdef EXMEM_SKID_EN
                if (accept && pop) begin
                    main_d = in_beat;
                end else if (accept) begin
                    state_d = S_FULL;
                    skid_d  = in_beat;
                end else if (pop) begin
                    state_d = S_EMPTY;
                end
`else
                // Single entry: an accept while occupied always coincides with a pop.
                if (accept) begin
                    main_d = in_beat;
                end else if (pop) begin
                    state_d = S_EMPTY;
                end
`endif
            end
`ifdef EXMEM_SKID_EN
            S_FULL: begin
                if (pop) begin
                    state_d = S_ONE;
                    main_d  = skid_q;
                end
            end
`endif
            default: state_d = S_EMPTY;
        endcase
        if (flush) begin
            state_d = S_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
            main_q  <= '0;
`ifdef EXMEM_SKID_EN
            skid_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
`ifdef EXMEM_SKID_EN
            skid_q  <= skid_d;
`endif
        end
    end

    // Bubbles never expose stale register contents to the memory stage.
    always_comb begin
        o_pc        = '0;
        o_inst_data = '0;
        o_rd_idx    = '0;
        o_rs1_data  = '0;
        o_rs2_data  = '0;
        o_imm_data  = '0;
        o_mem_op    = `MEMOP_NONE;
        o_exc       = '0;
        if (out_valid) begin
            o_pc        = main_q.pc;
            o_inst_data = main_q.inst_data;
            o_rd_idx    = main_q.rd_idx;
            o_rs1_data  = main_q.rs1_data;
            o_rs2_data  = main_q.rs2_data;
            o_imm_data  = main_q.imm_data;
            o_mem_op    = main_q.mem_op;
            o_exc       = main_q.exc;
        end
    end

endmodule

// File: tb/tb_ex_mem_reg.sv
// Randomized self-checking bench for ex_mem_reg against a queue-based FIFO reference model.
`ifndef XLEN
`define XLEN 64
`endif
`ifndef REG_ADDRWIDTH
`define REG_ADDRWIDTH 5
`endif
`ifndef IMM_LEN
`define IMM_LEN 64
`endif
`ifndef MEMOP_LEN
`define MEMOP_LEN 4
`endif
`ifndef MEMOP_NONE
`define MEMOP_NONE 4'hF
`endif

module tb_ex_mem_reg;

    typedef struct packed {
        logic [`XLEN-1:0]          pc;
        logic [`XLEN-1:0]          inst_data;
        logic [`REG_ADDRWIDTH-1:0] rd_idx;
        logic [`XLEN-1:0]          rs1_data;
        logic [`XLEN-1:0]          rs2_data;
        logic [`IMM_LEN-1:0]       imm_data;
        logic [`MEMOP_LEN-1:0]     mem_op;
        logic [`XLEN-1:0]          exc;
    } beat_t;

`ifdef EXMEM_SKID_EN
    localparam int unsigned CAP = 2;
`else
    localparam int unsigned CAP = 1;
`endif

    logic clk = 1'b0;
    logic rst, flush, in_valid, in_ready, out_valid, out_ready;
    beat_t drv;
    logic [`XLEN-1:0]          o_pc, o_inst_data, o_rs1_data, o_rs2_data, o_exc;
    logic [`REG_ADDRWIDTH-1:0] o_rd_idx;
    logic [`IMM_LEN-1:0]       o_imm_data;
    logic [`MEMOP_LEN-1:0]     o_mem_op;

    int unsigned cmp_count  = 0;
    int unsigned fail_count = 0;
    bit          checking   = 1'b0;
    beat_t       model_q[$];

    always #5 clk = ~clk;

    ex_mem_reg dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .i_pc(drv.pc), .i_inst_data(drv.inst_data), .i_rd_idx(drv.rd_idx),
        .i_rs1_data(drv.rs1_data), .i_rs2_data(drv.rs2_data), .i_imm_data(drv.imm_data),
        .i_mem_op(drv.mem_op), .i_exc(drv.exc),
        .out_valid(out_valid), .out_ready(out_ready),
        .o_pc(o_pc), .o_inst_data(o_inst_data), .o_rd_idx(o_rd_idx),
        .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data), .o_imm_data(o_imm_data),
        .o_mem_op(o_mem_op), .o_exc(o_exc)
    );

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        cmp_count++;
        if (got !== exp) begin
            fail_count++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic beat_t rand_beat(input logic [`XLEN-1:0] pc);
        beat_t b;
        b.pc        = pc;
        b.inst_data = {$urandom, $urandom};
        b.rd_idx    = `REG_ADDRWIDTH'($urandom);
        b.rs1_data  = {$urandom, $urandom};
        b.rs2_data  = {$urandom, $urandom};
        b.imm_data  = {$urandom, $urandom};
        b.mem_op    = `MEMOP_LEN'($urandom);
        b.exc       = {$urandom, $urandom};
        return b;
    endfunction

    // One clock: drive at the falling edge, check before the rising edge, then advance the model.
    task automatic cycle(input logic r, input logic f, input logic v, input logic ordy, input beat_t b);
        beat_t idle;
        beat_t exp_head;
        beat_t got_head;
        logic  exp_ready, exp_valid;
        @(negedge clk);
        rst = r; flush = f; in_valid = v; out_ready = ordy; drv = b;
        #1;
        exp_valid = (model_q.size() != 0);
        if (CAP == 2) exp_ready = ~r & (model_q.size() < 2);
        else          exp_ready = ~r & ((model_q.size() == 0) | ordy);
        idle = '0;
        idle.mem_op = `MEMOP_NONE;
        exp_head = exp_valid ? model_q[0] : idle;
        got_head = {o_pc, o_inst_data, o_rd_idx, o_rs1_data, o_rs2_data, o_imm_data, o_mem_op, o_exc};
        if (checking) begin
            check_eq("in_ready", 512'(in_ready), 512'(exp_ready));
            check_eq("out_valid", 512'(out_valid), 512'(exp_valid));
            check_eq("o_pc", 512'(o_pc), 512'(exp_head.pc));
            check_eq("o_mem_op", 512'(o_mem_op), 512'(exp_head.mem_op));
            check_eq("head", 512'(got_head), 512'(exp_head));
        end
        @(posedge clk);
        if (r || f) begin
            model_q.delete();
        end else begin
            if (exp_valid && ordy) void'(model_q.pop_front());
            if (v && exp_ready) model_q.push_back(b);
        end
    endtask

    initial begin
        beat_t b;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; drv = '0;

        // Reset held three cycles with in_valid high; the first cycle starts from unknown state.
        cycle(1, 0, 1, 1, rand_beat(64'h1234));
        checking = 1'b1;
        cycle(1, 0, 1, 1, rand_beat(64'h1238));
        cycle(1, 0, 1, 1, rand_beat(64'h123C));
        cycle(0, 0, 0, 1, '0);

        // Streaming at full rate.
        for (int unsigned i = 0; i < 4; i++) cycle(0, 0, 1, 1, rand_beat(64'h8000_0000 + 64'(4 * i)));
        cycle(0, 0, 0, 1, '0);
        cycle(0, 0, 0, 1, '0);

        // Backpressure then drain.
        cycle(0, 0, 1, 0, rand_beat(64'h8000_0000));
        cycle(0, 0, 1, 0, rand_beat(64'h8000_0004));
        cycle(0, 0, 0, 0, '0);
        cycle(0, 0, 0, 1, '0);
        cycle(0, 0, 0, 1, '0);
        cycle(0, 0, 0, 1, '0);

        // Flush while holding beats, with a same-cycle input beat.
        cycle(0, 0, 1, 0, rand_beat(64'h8000_0008));
        cycle(0, 0, 1, 0, rand_beat(64'h8000_000C));
        cycle(0, 1, 1, 0, rand_beat(64'h8000_0010));
        cycle(0, 0, 0, 1, '0);
        cycle(0, 0, 0, 1, '0);

        // Store followed by idle: the bubble must not look like a store.
        b = rand_beat(64'h8000_0020);
        b.rs2_data = 64'hDEAD_BEEF;
        b.exc      = 64'h8000_1000;
        b.mem_op   = 4'h3;
        cycle(0, 0, 1, 1, b);
        cycle(0, 0, 0, 1, '0);
        cycle(0, 0, 0, 1, '0);

        // Random traffic including occasional flush and reset.
        for (int unsigned i = 0; i < 400; i++) begin
            cycle(($urandom_range(49) == 0), ($urandom_range(19) == 0),
                  ($urandom_range(9) < 7), ($urandom_range(9) < 6),
                  rand_beat(64'h9000_0000 + 64'(4 * i)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", cmp_count, fail_count);
        $finish;
    end

endmodule
